// File: rtl/power_isa_pkg.sv
// Shared Power ISA decode definitions: prefix opcode and the packer state encoding.
package power_isa_pkg;

   localparam logic [5:0] PREFIX_OPC_DEFAULT = 6'b100000;

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_PREFIX = 2'd1,
      S_OUT    = 2'd2
   } pack_state_e;

   function automatic logic is_prefix_opc(input logic [31:0] word, input logic [5:0] opc);
      return word[5:0] == opc;
   endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Upstream word handshake and downstream packed-instruction handshake of the packer.
interface instr_packer_if;
   logic        i_word_valid;
   logic [31:0] i_word;
   logic        o_word_ready;
   logic        o_instr_valid;
   logic [63:0] o_instr;
   logic        o_is_prefixed;
   logic        o_align_err;
   logic        i_instr_ready;

   modport slave (
      input  i_word_valid, i_word, i_instr_ready,
      output o_word_ready, o_instr_valid, o_instr, o_is_prefixed, o_align_err
   );

   modport master (
      output i_word_valid, i_word, i_instr_ready,
      input  o_word_ready, o_instr_valid, o_instr, o_is_prefixed, o_align_err
   );
endinterface

// File: rtl/instr_packer.sv
// Joins a 32-bit prefix word with its suffix into one 64-bit instruction for decode,
// flagging prefixes that sit in the last word of a 64-byte block.
module instr_packer
   import power_isa_pkg::*;
#(
   parameter logic [5:0] PREFIX_OPC = PREFIX_OPC_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_flush,
   input  logic [3:0]            i_flush_idx,
   instr_packer_if.slave         bus
);

   pack_state_e state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] prefix_q, prefix_d;
   logic [63:0] instr_q, instr_d;
   logic        is_pref_q, is_pref_d;
   logic        align_q, align_d;
   logic        accept;

   // Ready is held low during reset so nothing is taken while state is being cleared.
   assign bus.o_word_ready  = ~i_rst & i_en & ~i_flush &
                              ((state_q != S_OUT) | bus.i_instr_ready);
   assign bus.o_instr_valid = i_en & (state_q == S_OUT);
   assign bus.o_instr       = instr_q;
   assign bus.o_is_prefixed = is_pref_q;
   assign bus.o_align_err   = align_q;

   assign accept = bus.i_word_valid & bus.o_word_ready;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      prefix_d  = prefix_q;
      instr_d   = instr_q;
      is_pref_d = is_pref_q;
      align_d   = align_q;
      if (i_flush) begin
         state_d = S_EMPTY;
         idx_d   = i_flush_idx;
      end else if (i_en) begin
         if (accept) begin
            idx_d = idx_q + 4'd1;
            if (state_q == S_PREFIX) begin
               // Suffix is taken as-is, whatever its opcode.
               instr_d   = {bus.i_word, prefix_q};
               is_pref_d = 1'b1;
               align_d   = 1'b0;
               state_d   = S_OUT;
            end else if (is_prefix_opc(bus.i_word, PREFIX_OPC)) begin
               if (idx_q == 4'd15) begin
                  instr_d   = {32'b0, bus.i_word};
                  is_pref_d = 1'b1;
                  align_d   = 1'b1;
                  state_d   = S_OUT;
               end else begin
                  prefix_d = bus.i_word;
                  state_d  = S_PREFIX;
               end
            end else begin
               instr_d   = {32'b0, bus.i_word};
               is_pref_d = 1'b0;
               align_d   = 1'b0;
               state_d   = S_OUT;
            end
         end else if ((state_q == S_OUT) && bus.i_instr_ready) begin
            state_d = S_EMPTY;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_EMPTY;
         idx_q     <= 4'd0;
         prefix_q  <= 32'b0;
         instr_q   <= 64'b0;
         is_pref_q <= 1'b0;
         align_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         prefix_q  <= prefix_d;
         instr_q   <= instr_d;
         is_pref_q <= is_pref_d;
         align_q   <= align_d;
      end
   end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: single words, prefix pairs, stalls, flush and reset.
module tb_instr_packer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       flush;
   logic [3:0] flush_idx;
   int         n_checks;
   int         n_fail;

   instr_packer_if bus ();

   instr_packer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_flush     (flush),
      .i_flush_idx (flush_idx),
      .bus         (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic valid, input logic [63:0] instr,
                            input logic pref, input logic align);
      check({tag, ".valid"}, 64'(bus.o_instr_valid), 64'(valid));
      if (valid) begin
         check({tag, ".instr"}, bus.o_instr, instr);
         check({tag, ".pref"}, 64'(bus.o_is_prefixed), 64'(pref));
         check({tag, ".align"}, 64'(bus.o_align_err), 64'(align));
      end
   endtask

   logic [31:0] stream [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      stream[0] = 32'h0000_00B2;
      stream[1] = 32'h0000_00C3;
      stream[2] = 32'h0000_00D4;
      stream[3] = 32'h0000_00E5;
      rst = 1'b1;
      en = 1'b1;
      flush = 1'b0;
      flush_idx = 4'd0;
      bus.i_word_valid  = 1'b0;
      bus.i_word        = 32'h0;
      bus.i_instr_ready = 1'b1;

      // Reset state
      #3;
      check("rst.ready", 64'(bus.o_word_ready), 64'd0);
      check("rst.valid", 64'(bus.o_instr_valid), 64'd0);
      check("rst.instr", bus.o_instr, 64'd0);
      check("rst.pref", 64'(bus.o_is_prefixed), 64'd0);
      check("rst.align", 64'(bus.o_align_err), 64'd0);
      #19 rst = 1'b0;
      #1 check("idle.ready", 64'(bus.o_word_ready), 64'd1);

      // Single unprefixed word (index 0 -> 1)
      tick();
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0012;
      tick();
      bus.i_word_valid = 1'b0;
      check_out("single", 1'b1, 64'h0000_0000_0000_0012, 1'b0, 1'b0);
      tick();
      check_out("single.drain", 1'b0, 64'h0, 1'b0, 1'b0);

      // Prefix + suffix (index 1 -> 3)
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0020;
      tick();
      check_out("pair.held", 1'b0, 64'h0, 1'b0, 1'b0);
      bus.i_word = 32'h1234_5678;
      tick();
      bus.i_word_valid = 1'b0;
      check_out("pair", 1'b1, 64'h1234_5678_0000_0020, 1'b1, 1'b0);
      tick();
      check_out("pair.once", 1'b0, 64'h0, 1'b0, 1'b0);

      // Backpressure for three cycles, then streaming (index 3 -> 8)
      bus.i_instr_ready = 1'b0;
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_00A1;
      tick();
      bus.i_word = stream[0];
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall.ready", 64'(bus.o_word_ready), 64'd0);
         check_out("stall", 1'b1, 64'h0000_0000_0000_00A1, 1'b0, 1'b0);
         tick();
      end
      bus.i_instr_ready = 1'b1;
      #1 check("stall.release", 64'(bus.o_word_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_out("stream", 1'b1, {32'b0, stream[i]}, 1'b0, 1'b0);
         if (i < 3) bus.i_word = stream[i + 1];
         else bus.i_word_valid = 1'b0;
      end

      // Enable low freezes the output register even with ready high
      en = 1'b0;
      #1;
      check("en_low.valid", 64'(bus.o_instr_valid), 64'd0);
      check("en_low.ready", 64'(bus.o_word_ready), 64'd0);
      tick();
      en = 1'b1;
      #1 check_out("en_resume", 1'b1, {32'b0, stream[3]}, 1'b0, 1'b0);
      tick();
      check_out("en_drain", 1'b0, 64'h0, 1'b0, 1'b0);

      // Flush to index 15; the word offered during the flush is ignored
      flush = 1'b1;
      flush_idx = 4'd15;
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0020;
      #1 check("flush.ready", 64'(bus.o_word_ready), 64'd0);
      tick();
      flush = 1'b0;
      check_out("flush.empty", 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      check_out("align", 1'b1, 64'h0000_0000_0000_0020, 1'b1, 1'b1);
      // Index wrapped to 0: a prefix now pairs normally
      tick();
      check_out("wrap.held", 1'b0, 64'h0, 1'b0, 1'b0);
      bus.i_word = 32'h0000_0055;
      tick();
      bus.i_word_valid = 1'b0;
      check_out("wrap.pair", 1'b1, 64'h0000_0055_0000_0020, 1'b1, 1'b0);
      tick();

      // Flush while a prefix is held
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0020;
      tick();
      bus.i_word_valid = 1'b0;
      flush = 1'b1;
      flush_idx = 4'd3;
      tick();
      flush = 1'b0;
      check_out("flush_pfx", 1'b0, 64'h0, 1'b0, 1'b0);
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0012;
      tick();
      bus.i_word_valid = 1'b0;
      check_out("flush_pfx.next", 1'b1, 64'h0000_0000_0000_0012, 1'b0, 1'b0);
      tick();

      // Asynchronous reset while a prefix is held
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0020;
      tick();
      bus.i_word_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_pfx.ready", 64'(bus.o_word_ready), 64'd0);
      check("rst_pfx.valid", 64'(bus.o_instr_valid), 64'd0);
      check("rst_pfx.instr", bus.o_instr, 64'd0);
      #1 rst = 1'b0;
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0012;
      tick();
      bus.i_word_valid = 1'b0;
      check_out("rst_pfx.next", 1'b1, 64'h0000_0000_0000_0012, 1'b0, 1'b0);
      tick();
      check_out("rst_pfx.drain", 1'b0, 64'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
